// File: rtl/sm83_idu_seq.sv
// Byte-serial 16-bit increment/decrement unit: low byte, then high byte with
// the latched carry/borrow, then a registered result plus wrap/OAM/error flags.
module sm83_idu_seq #(
    parameter int                W_BYTE   = 8,
    parameter logic [W_BYTE-1:0] OAM_PAGE = 8'hFE
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  op_inc,
    input  logic                  op_dec,
    input  logic [2*W_BYTE-1:0]   operand,
    output logic                  busy,
    output logic                  done,
    output logic [2*W_BYTE-1:0]   result,
    output logic                  wrap,
    output logic                  oam_bug,
    output logic                  op_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam logic [W_BYTE:0] ONE = {{W_BYTE{1'b0}}, 1'b1};

    state_t              state;
    logic [2*W_BYTE-1:0] opnd;
    logic                add_q;
    logic                sub_q;
    logic                err_q;
    logic [W_BYTE-1:0]   lo_q;
    logic                c_q;

    logic [W_BYTE:0] step_lo;
    logic [W_BYTE:0] step_hi;
    logic [W_BYTE:0] lo_sum;
    logic [W_BYTE:0] hi_sum;

    // Bit W_BYTE of each sum is the carry (add) or borrow (sub) out of that byte.
    always_comb begin
        step_lo = (add_q | sub_q) ? ONE : '0;
        step_hi = {{W_BYTE{1'b0}}, c_q};
        if (sub_q) begin
            lo_sum = {1'b0, opnd[W_BYTE-1:0]} - step_lo;
            hi_sum = {1'b0, opnd[2*W_BYTE-1:W_BYTE]} - step_hi;
        end else begin
            lo_sum = {1'b0, opnd[W_BYTE-1:0]} + step_lo;
            hi_sum = {1'b0, opnd[2*W_BYTE-1:W_BYTE]} + step_hi;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            opnd    <= '0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            wrap    <= 1'b0;
            oam_bug <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= operand;
                        add_q <= op_inc & ~op_dec;
                        sub_q <= op_dec & ~op_inc;
                        err_q <= op_inc & op_dec;
                        busy  <= 1'b1;
                        state <= LO;
                    end
                end
                LO: begin
                    lo_q  <= lo_sum[W_BYTE-1:0];
                    c_q   <= lo_sum[W_BYTE];
                    state <= HI;
                end
                HI: begin
                    result  <= {hi_sum[W_BYTE-1:0], lo_q};
                    wrap    <= hi_sum[W_BYTE];
                    oam_bug <= (add_q | sub_q) &&
                               (opnd[2*W_BYTE-1:W_BYTE] == OAM_PAGE);
                    op_err  <= err_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_idu_seq.sv
// Self-checking bench for sm83_idu_seq: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_sm83_idu_seq;

    logic        clk;
    logic        nreset;
    logic        start;
    logic        op_inc;
    logic        op_dec;
    logic [15:0] operand;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        wrap;
    logic        oam_bug;
    logic        op_err;

    int total;
    int bad;

    sm83_idu_seq dut (
        .clk     (clk),
        .nreset  (nreset),
        .start   (start),
        .op_inc  (op_inc),
        .op_dec  (op_dec),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wrap    (wrap),
        .oam_bug (oam_bug),
        .op_err  (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole 16-bit value arithmetic, no byte split.
    function automatic void model(input logic [15:0] x, input logic inc,
                                  input logic dec, output logic [15:0] r,
                                  output logic w, output logic o,
                                  output logic e);
        int v;
        v = int'(x);
        r = x;
        w = 1'b0;
        o = 1'b0;
        e = inc && dec;
        if (inc && !dec) begin
            v = v + 1;
            w = (v > 65535);
            r = 16'(v % 65536);
            o = (x[15:8] == 8'hFE);
        end else if (dec && !inc) begin
            v = v - 1;
            w = (v < 0);
            r = 16'((v + 65536) % 65536);
            o = (x[15:8] == 8'hFE);
        end
    endfunction

    // Issues one op and waits for done; inputs are scrambled after accept.
    task automatic do_op(input logic [15:0] x, input logic inc,
                         input logic dec, output int lat, output int nbusy);
        @(negedge clk);
        start   = 1'b1;
        operand = x;
        op_inc  = inc;
        op_dec  = dec;
        lat     = 0;
        nbusy   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                operand = 16'($urandom);
                op_inc  = 1'($urandom);
                op_dec  = 1'($urandom);
            end
            lat++;
            if (done) break;
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        start = 1'b0;
        op_inc = 1'b0;
        op_dec = 1'b0;
        operand = 16'h0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        total++;
        if ({result, busy, done, wrap, oam_bug, op_err} !== 21'h0) begin
            bad++;
            $display("FAIL reset: got res=%h busy=%b done=%b flags=%b%b%b want all 0",
                     result, busy, done, wrap, oam_bug, op_err);
        end
    endtask

    task automatic test_inc_carry;
        int lat, nb;
        do_op(16'h12FF, 1'b1, 1'b0, lat, nb);
        total++;
        if (lat !== 3 || nb !== 2) begin
            bad++;
            $display("FAIL latency: got lat=%0d busy=%0d want 3/2", lat, nb);
        end
        total++;
        if (result !== 16'h1300 || wrap !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL inc_12ff: got %h w=%b busy=%b want 1300 w=0 busy=0",
                     result, wrap, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || result !== 16'h1300) begin
            bad++;
            $display("FAIL done_pulse: got done=%b res=%h want 0/1300", done, result);
        end
    endtask

    task automatic test_wrap;
        int lat, nb;
        do_op(16'hFFFF, 1'b1, 1'b0, lat, nb);
        total++;
        if (result !== 16'h0000 || wrap !== 1'b1 || lat !== 3) begin
            bad++;
            $display("FAIL inc_ffff: got %h w=%b lat=%0d want 0000 w=1 lat=3",
                     result, wrap, lat);
        end
        do_op(16'h0000, 1'b0, 1'b1, lat, nb);
        total++;
        if (result !== 16'hFFFF || wrap !== 1'b1) begin
            bad++;
            $display("FAIL dec_0000: got %h w=%b want FFFF w=1", result, wrap);
        end
        do_op(16'h0100, 1'b0, 1'b1, lat, nb);
        total++;
        if (result !== 16'h00FF || wrap !== 1'b0) begin
            bad++;
            $display("FAIL dec_0100: got %h w=%b want 00FF w=0", result, wrap);
        end
    endtask

    task automatic test_oam;
        int lat, nb;
        do_op(16'hFE40, 1'b0, 1'b1, lat, nb);
        total++;
        if (result !== 16'hFE3F || oam_bug !== 1'b1) begin
            bad++;
            $display("FAIL oam_fe40: got %h oam=%b want FE3F oam=1", result, oam_bug);
        end
        do_op(16'hFEFF, 1'b1, 1'b0, lat, nb);
        total++;
        if (result !== 16'hFF00 || oam_bug !== 1'b1) begin
            bad++;
            $display("FAIL oam_feff: got %h oam=%b want FF00 oam=1", result, oam_bug);
        end
        do_op(16'hFF00, 1'b0, 1'b1, lat, nb);
        total++;
        if (result !== 16'hFEFF || oam_bug !== 1'b0) begin
            bad++;
            $display("FAIL oam_ff00: got %h oam=%b want FEFF oam=0", result, oam_bug);
        end
    endtask

    task automatic test_pass_err;
        int lat, nb;
        do_op(16'hA5A5, 1'b0, 1'b0, lat, nb);
        total++;
        if (result !== 16'hA5A5 || {wrap, oam_bug, op_err} !== 3'b000) begin
            bad++;
            $display("FAIL pass: got %h flags=%b%b%b want A5A5 000",
                     result, wrap, oam_bug, op_err);
        end
        do_op(16'h1234, 1'b1, 1'b1, lat, nb);
        total++;
        if (result !== 16'h1234 || op_err !== 1'b1 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL err: got %h err=%b w=%b want 1234 err=1 w=0",
                     result, op_err, wrap);
        end
        do_op(16'hFEFF, 1'b1, 1'b1, lat, nb);
        total++;
        if (result !== 16'hFEFF || {wrap, oam_bug, op_err} !== 3'b001) begin
            bad++;
            $display("FAIL err_fe: got %h flags=%b%b%b want FEFF 001",
                     result, wrap, oam_bug, op_err);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start   = 1'b1;
        operand = 16'h00FF;
        op_inc  = 1'b1;
        op_dec  = 1'b0;
        @(negedge clk);
        operand = 16'h7777;
        op_dec  = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL held_busy: got busy=%b done=%b want 1/0", busy, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || result !== 16'h0100) begin
            bad++;
            $display("FAIL held_first: got done=%b res=%h want 1/0100", done, result);
        end
        operand = 16'h8000;
        op_inc  = 1'b0;
        op_dec  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_mid: got done=%b busy=%b want 0/1", done, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || result !== 16'h7FFF || wrap !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got done=%b res=%h w=%b want 1/7FFF/0",
                     done, result, wrap);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nb;
        int seen;
        @(negedge clk);
        start   = 1'b1;
        operand = 16'h4444;
        op_inc  = 1'b1;
        op_dec  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || result !== 16'h0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b res=%h done=%b want 0/0000/0",
                     busy, result, done);
        end
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_nodone: got %0d active cycles want 0", seen);
        end
        do_op(16'h0001, 1'b1, 1'b0, lat, nb);
        total++;
        if (result !== 16'h0002 || lat !== 3) begin
            bad++;
            $display("FAIL after_reset: got %h lat=%0d want 0002 lat=3", result, lat);
        end
    endtask

    task automatic test_random;
        int lat, nb;
        logic [15:0] x, er;
        logic inc, dec, ew, eo, ee;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: x = 16'hFE00 | 16'($urandom_range(0, 255));
                1: x = $urandom_range(0, 1) ? 16'hFFFF : 16'h0000;
                default: x = 16'($urandom);
            endcase
            inc = 1'($urandom);
            dec = 1'($urandom);
            model(x, inc, dec, er, ew, eo, ee);
            do_op(x, inc, dec, lat, nb);
            total++;
            if (lat !== 3 || result !== er || wrap !== ew ||
                oam_bug !== eo || op_err !== ee) begin
                bad++;
                $display("FAIL rand x=%h i=%b d=%b: got %h %b%b%b lat=%0d want %h %b%b%b lat=3",
                         x, inc, dec, result, wrap, oam_bug, op_err, lat,
                         er, ew, eo, ee);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_inc_carry;
        test_wrap;
        test_oam;
        test_pass_err;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
